// File: rtl/power_trig_ctrl.sv
// power_trig_ctrl: settings-bus programmed sequencer for the power-trigger datapath.
// Arms the power detector, waits for a detect pulse, gates a programmed number of
// post-trigger DDC samples to the baseband sink, then holds off before re-arming
// (continuous) or returning idle (single shot).
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   set_stb/set_addr/set_data    settings bus write (CTRL, POST, HOLD, TMO at BASE+0..3)
//   ddc_out_sample/_strobe       DDC sample stream in
//   trig_det                     power-detect pulse, qualified by ddc_out_strobe
//   pt_enable                    power detector enable, high only while ARMED
//   bb_sample/bb_strobe          gated sample stream out, one cycle latency
//   done, timeout                one-cycle completion / arm-timeout pulses
//   status                       {trig_count[15:0], 12'b0, state[1:0], cont, armed}
module power_trig_ctrl #(
   parameter int unsigned BASE  = 0,
   parameter int unsigned CNT_W = 16,
   parameter int unsigned TO_W  = 24
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic [31:0] ddc_out_sample,
   input  logic        ddc_out_strobe,
   input  logic        trig_det,
   output logic        pt_enable,
   output logic [31:0] bb_sample,
   output logic        bb_strobe,
   output logic        done,
   output logic        timeout,
   output logic [31:0] status
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_HOLDOFF = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   state_t             w_exit_state;

   logic               r_cont;
   logic [CNT_W-1:0]   r_post;
   logic [CNT_W-1:0]   r_hold;
   logic [TO_W-1:0]    r_tmo;

   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [CNT_W-1:0]   w_post_m1;
   logic [TO_W-1:0]    r_tmr;
   logic [TO_W-1:0]    w_tmr_nxt;
   logic [15:0]        r_trig_count;

   logic               r_armed;
   logic               r_bb_strobe;
   logic [31:0]        r_bb_sample;
   logic               r_done;
   logic               r_timeout;

   logic               w_ctrl_wr;
   logic               w_arm;
   logic               w_abort;
   logic               w_pass;
   logic               w_last;
   logic               w_timeout;
   logic               w_trig;
   logic               w_unused;

   // Settings decode; ABORT takes priority over ARM inside the FSM
   assign w_ctrl_wr = set_stb && (set_addr == 8'(BASE));
   assign w_arm     = w_ctrl_wr && set_data[0];
   assign w_abort   = w_ctrl_wr && set_data[2];

   // Samples still to pass after the trigger sample; POST=0 behaves as POST=1
   assign w_post_m1    = (r_post == '0) ? '0 : r_post - CNT_W'(1);
   assign w_exit_state = r_cont ? S_ARMED : S_IDLE;

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state, counter updates and gating decisions
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_tmr_nxt   = (r_state == S_ARMED) ? r_tmr : '0;
      w_pass      = 1'b0;
      w_last      = 1'b0;
      w_timeout   = 1'b0;
      w_trig      = 1'b0;

      if (w_abort) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_tmr_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_arm) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
               if (ddc_out_strobe) begin
                  if (trig_det) begin
                     // Trigger sample is the first passed sample
                     w_trig    = 1'b1;
                     w_pass    = 1'b1;
                     w_tmr_nxt = '0;
                     if (w_post_m1 == '0) begin
                        w_last = 1'b1;
                     end else begin
                        w_state_nxt = S_CAPTURE;
                        w_cnt_nxt   = w_post_m1;
                     end
                  end else if ((r_tmo != '0) && (r_tmr == r_tmo - TO_W'(1))) begin
                     w_timeout   = 1'b1;
                     w_state_nxt = S_IDLE;
                     w_tmr_nxt   = '0;
                  end else begin
                     w_tmr_nxt = r_tmr + TO_W'(1);
                  end
               end
            end
            S_CAPTURE: begin
               if (ddc_out_strobe) begin
                  w_pass = 1'b1;
                  if (r_cnt == CNT_W'(1)) w_last    = 1'b1;
                  else                    w_cnt_nxt = r_cnt - CNT_W'(1);
               end
            end
            S_HOLDOFF: begin
               if (ddc_out_strobe) begin
                  if (r_cnt == CNT_W'(1)) begin
                     w_state_nxt = w_exit_state;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_cnt_nxt = r_cnt - CNT_W'(1);
                  end
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase

         // Capture finished on this strobe: hold off or leave directly
         if (w_last) begin
            if (r_hold != '0) begin
               w_state_nxt = S_HOLDOFF;
               w_cnt_nxt   = r_hold;
            end else begin
               w_state_nxt = w_exit_state;
               w_cnt_nxt   = '0;
            end
         end
      end
   end

   // Counters, configuration and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cont       <= 1'b0;
         r_post       <= '0;
         r_hold       <= '0;
         r_tmo        <= '0;
         r_cnt        <= '0;
         r_tmr        <= '0;
         r_trig_count <= '0;
         r_armed      <= 1'b0;
         r_bb_strobe  <= 1'b0;
         r_bb_sample  <= '0;
         r_done       <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_tmr       <= w_tmr_nxt;
         r_armed     <= (w_state_nxt == S_ARMED);
         r_bb_strobe <= w_pass;
         r_done      <= w_last;
         r_timeout   <= w_timeout;
         if (w_pass) r_bb_sample <= ddc_out_sample;
         if (w_trig && (r_trig_count != 16'hFFFF)) r_trig_count <= r_trig_count + 16'd1;
         if (w_ctrl_wr) r_cont <= set_data[1];
         if (set_stb && (set_addr == 8'(BASE + 1))) r_post <= set_data[CNT_W-1:0];
         if (set_stb && (set_addr == 8'(BASE + 2))) r_hold <= set_data[CNT_W-1:0];
         if (set_stb && (set_addr == 8'(BASE + 3))) r_tmo  <= set_data[TO_W-1:0];
      end
   end

   assign pt_enable = r_armed;
   assign bb_strobe = r_bb_strobe;
   assign bb_sample = r_bb_sample;
   assign done      = r_done;
   assign timeout   = r_timeout;
   assign status    = {r_trig_count, 12'b0, 2'(r_state), r_cont, r_armed};

   // Settings data bits above the programmed field widths are don't-care
   assign w_unused = ^set_data;

endmodule
